// File: rtl/i2s_rx_sync_if.sv
// Stereo I2S receive bundle.
// Groups the asynchronous I2S lines, the error-clear request and the
// deserialised stereo outputs of i2s_rx_sync.
//   bclk, lrclk, sdata : I2S bit clock, word select (0 = left) and serial data
//   clear_err          : request to clear the sticky frame_err flag
//   left_chan          : last complete left word
//   right_chan         : last complete right word
//   valid              : one-cycle strobe, new stereo pair on left_chan/right_chan
//   frame_err          : sticky, a channel ended before BITSIZE bits arrived
// master: the side that drives the I2S lines and consumes samples.
// slave : the receiver itself.
interface i2s_rx_sync_if #(
  parameter int unsigned BITSIZE = 16
) ();

  logic               bclk;
  logic               lrclk;
  logic               sdata;
  logic               clear_err;
  logic [BITSIZE-1:0] left_chan;
  logic [BITSIZE-1:0] right_chan;
  logic               valid;
  logic               frame_err;

  modport master (
    output bclk,
    output lrclk,
    output sdata,
    output clear_err,
    input  left_chan,
    input  right_chan,
    input  valid,
    input  frame_err
  );

  modport slave (
    input  bclk,
    input  lrclk,
    input  sdata,
    input  clear_err,
    output left_chan,
    output right_chan,
    output valid,
    output frame_err
  );

endinterface

// File: rtl/i2s_rx_sync.sv
// I2S receiver for the codec ADC path (codec is bit-clock master).
// Oversamples bclk/lrclk/sdata in the system clock domain, deserialises
// MSB-first left/right words of BITSIZE bits and presents them as one stereo
// sample with a one-cycle valid strobe.
// Ports:
//   clk   : system clock, at least 4x the bit clock
//   reset : synchronous, active-high
//   bus   : i2s_rx_sync_if slave modport (I2S lines, clear_err, stereo outputs)
module i2s_rx_sync #(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned SYNC    = 2
) (
  input logic          clk,
  input logic          reset,
  i2s_rx_sync_if.slave bus
);

  // One extra bit so the counter can also express BITSIZE for the align shift.
  localparam int unsigned CntW = $clog2(BITSIZE) + 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [SYNC-1:0]    bclk_sync_q, lrclk_sync_q, sdata_sync_q;
  logic               bclk_s, lrclk_s, sdata_s;
  logic               bclk_d1_q;
  logic               lr_prev_q;
  logic               rise, word_start;

  logic [CntW-1:0]    cnt_q;
  logic [BITSIZE-1:0] shift_q;
  logic               chan_q;
  logic [BITSIZE-1:0] left_hold_q;
  logic [BITSIZE-1:0] left_q, right_q;
  logic               valid_q;
  logic               err_q;

  logic [BITSIZE-1:0] shift_next, partial;
  logic [CntW-1:0]    shamt;
  logic               last_bit;

  logic               load_start, shift_en, commit, short_word;
  logic [BITSIZE-1:0] commit_word;

  // Identical chains keep the three lines aligned to each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sdata_sync_q <= '0;
      bclk_d1_q    <= 1'b0;
      lr_prev_q    <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[SYNC-2:0], bus.bclk};
      lrclk_sync_q <= {lrclk_sync_q[SYNC-2:0], bus.lrclk};
      sdata_sync_q <= {sdata_sync_q[SYNC-2:0], bus.sdata};
      bclk_d1_q    <= bclk_s;
      if (rise) begin
        lr_prev_q <= lrclk_s;
      end
    end
  end

  assign bclk_s     = bclk_sync_q[SYNC-1];
  assign lrclk_s    = lrclk_sync_q[SYNC-1];
  assign sdata_s    = sdata_sync_q[SYNC-1];
  assign rise       = bclk_s & ~bclk_d1_q;
  assign word_start = rise & (lrclk_s != lr_prev_q);

  assign shift_next = {shift_q[BITSIZE-2:0], sdata_s};
  assign last_bit   = (cnt_q == CntW'(BITSIZE - 1));
  // A truncated word holds cnt_q bits in the LSBs; move them up to the MSBs.
  assign shamt      = CntW'(BITSIZE) - cnt_q;
  assign partial    = shift_q << shamt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (rise) begin
      unique case (state_q)
        StIdle: begin
          if (word_start && !lrclk_s) state_d = StShift;
        end
        StShift: begin
          if (word_start)    state_d = StShift;
          else if (last_bit) state_d = StDone;
        end
        StDone: begin
          if (word_start) state_d = StShift;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output / datapath control.
  always_comb begin
    load_start  = 1'b0;
    shift_en    = 1'b0;
    commit      = 1'b0;
    short_word  = 1'b0;
    commit_word = '0;
    if (rise) begin
      unique case (state_q)
        StIdle: begin
          load_start = word_start & ~lrclk_s;
        end
        StShift: begin
          if (word_start) begin
            // Close the truncated word and open the new one in the same cycle.
            load_start  = 1'b1;
            commit      = 1'b1;
            short_word  = 1'b1;
            commit_word = partial;
          end else begin
            shift_en = 1'b1;
            if (last_bit) begin
              commit      = 1'b1;
              commit_word = shift_next;
            end
          end
        end
        StDone: begin
          load_start = word_start;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      chan_q      <= 1'b0;
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (load_start) begin
        cnt_q   <= '0;
        shift_q <= '0;
        chan_q  <= lrclk_s;
      end else if (shift_en) begin
        shift_q <= shift_next;
        cnt_q   <= cnt_q + CntW'(1);
      end
      if (commit) begin
        if (!chan_q) begin
          left_hold_q <= commit_word;
        end else begin
          // Publish the pair together so both channels change in one cycle.
          right_q <= commit_word;
          left_q  <= left_hold_q;
          valid_q <= 1'b1;
        end
      end
      if (short_word) begin
        err_q <= 1'b1;
      end else if (bus.clear_err) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.left_chan  = left_q;
  assign bus.right_chan = right_q;
  assign bus.valid      = valid_q;
  assign bus.frame_err  = err_q;

endmodule
